// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: shared types and constants for the fetch PC generator.
//   redirect_cause_e     : which redirect source won arbitration this cycle.
//   group_bytes()        : bytes covered by one fetch group (4 per instruction).
//   DEFAULT_RESET_VECTOR : PC loaded by reset unless the top overrides it.
package fetch_pc_pkg;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'd0,
    REDIR_BR   = 2'd1,
    REDIR_EXC  = 2'd2
  } redirect_cause_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;

  function automatic int group_bytes(input int fetch_width);
    return 4 * fetch_width;
  endfunction

endpackage

// File: rtl/fetch_pc_redirect_arb.sv
// fetch_pc_redirect_arb: combinational priority select between the redirect
// sources. Exceptions beat branches; the losing branch is simply dropped.
//   exc_req / exc_target : exception or ERET redirect request and target
//   br_req  / br_target  : branch redirect request and target (already gated
//                          by the caller when branches must be ignored)
//   cause                : winning source, REDIR_NONE when nothing requests
//   target               : selected target address
//   misaligned           : selected target is not word aligned
module fetch_pc_redirect_arb
  import fetch_pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              exc_req,
  input  logic [ADDR_W-1:0] exc_target,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_target,
  output redirect_cause_e   cause,
  output logic [ADDR_W-1:0] target,
  output logic              misaligned
);

  always_comb begin
    cause  = REDIR_NONE;
    target = br_target;
    if (exc_req) begin
      cause  = REDIR_EXC;
      target = exc_target;
    end else if (br_req) begin
      cause  = REDIR_BR;
    end
  end

  assign misaligned = (cause != REDIR_NONE) && (target[1:0] != 2'b00);

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: program-counter generator for the instruction fetch stage.
// Presents one aligned fetch group of FETCH_WIDTH instructions per cycle and
// takes registered redirects (exception over branch) with one cycle latency.
// A misaligned redirect target parks the generator in a sticky fault that
// only an aligned exception redirect or reset can clear.
//
// Optional feature macro: FETCH_PC_PERF_CNT_EN enables the redirect and
// stall counters; without it both counter ports are tied to zero.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   fetch_ready_i      : fetch stage accepts the current group
//   br_redirect_i/br_target_i   : branch redirect request and target
//   exc_redirect_i/exc_target_i : exception/ERET redirect request and target
//   pc_o               : current fetch PC (registered)
//   pc_valid_o         : pc_o may be fetched
//   slot_mask_o        : valid instruction slots within the group
//   flush_o            : one-cycle pulse after a redirect is taken
//   alignment_error_o  : sticky misaligned-PC fault
//   redirect_cnt_o     : redirects taken
//   stall_cnt_o        : cycles with a valid group held back by the fetch stage
module fetch_pc_gen
  import fetch_pc_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              FETCH_WIDTH  = 2,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(DEFAULT_RESET_VECTOR)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_ready_i,
  input  logic                   br_redirect_i,
  input  logic [ADDR_W-1:0]      br_target_i,
  input  logic                   exc_redirect_i,
  input  logic [ADDR_W-1:0]      exc_target_i,
  output logic [ADDR_W-1:0]      pc_o,
  output logic                   pc_valid_o,
  output logic [FETCH_WIDTH-1:0] slot_mask_o,
  output logic                   flush_o,
  output logic                   alignment_error_o,
  output logic [31:0]            redirect_cnt_o,
  output logic [31:0]            stall_cnt_o
);

  localparam int GROUP_BYTES = group_bytes(FETCH_WIDTH);
  localparam int OFS_W       = $clog2(GROUP_BYTES);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic              valid_reg, valid_next;
  logic              fault_reg, fault_next;
  logic              flush_reg, flush_next;

  redirect_cause_e   redir_cause;
  logic [ADDR_W-1:0] redir_target;
  logic              redir_misaligned;
  logic              redir_taken;
  logic [ADDR_W-1:0] pc_advance;

  // While faulted the branch unit is most likely chasing a bogus path, so
  // only the exception unit is allowed to steer the PC.
  fetch_pc_redirect_arb #(
    .ADDR_W (ADDR_W)
  ) u_arb (
    .exc_req    (exc_redirect_i),
    .exc_target (exc_target_i),
    .br_req     (br_redirect_i && !fault_reg),
    .br_target  (br_target_i),
    .cause      (redir_cause),
    .target     (redir_target),
    .misaligned (redir_misaligned)
  );

  assign redir_taken = (redir_cause != REDIR_NONE);

  // Advancing always lands on the next group boundary, so an unaligned entry
  // into a group only costs the slots below the entry point once.
  assign pc_advance = {pc_reg[ADDR_W-1:OFS_W], {OFS_W{1'b0}}} + ADDR_W'(GROUP_BYTES);

  always_comb begin
    pc_next    = pc_reg;
    valid_next = valid_reg;
    fault_next = fault_reg;
    flush_next = 1'b0;
    if (redir_taken) begin
      pc_next    = redir_target;
      flush_next = 1'b1;
      fault_next = redir_misaligned;
      valid_next = !redir_misaligned;
    end else if (!fault_reg) begin
      // Also covers the first cycle after reset, when valid_reg is still low.
      valid_next = 1'b1;
      if (valid_reg && fetch_ready_i) begin
        pc_next = pc_advance;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg    <= RESET_VECTOR;
      valid_reg <= 1'b0;
      fault_reg <= 1'b0;
      flush_reg <= 1'b0;
    end else begin
      pc_reg    <= pc_next;
      valid_reg <= valid_next;
      fault_reg <= fault_next;
      flush_reg <= flush_next;
    end
  end

  assign pc_o              = pc_reg;
  assign pc_valid_o        = valid_reg;
  assign flush_o           = flush_reg;
  assign alignment_error_o = fault_reg;

  generate
    if (FETCH_WIDTH == 1) begin : g_mask_single
      assign slot_mask_o = valid_reg;
    end else begin : g_mask_multi
      logic [OFS_W-3:0] slot_idx;
      assign slot_idx = pc_reg[OFS_W-1:2];
      for (genvar gi = 0; gi < FETCH_WIDTH; gi++) begin : g_slot
        assign slot_mask_o[gi] = valid_reg && (slot_idx <= (OFS_W-2)'(gi));
      end
    end
  endgenerate

`ifdef FETCH_PC_PERF_CNT_EN
  logic [31:0] redirect_cnt_reg;
  logic [31:0] stall_cnt_reg;
  logic        stall_event;

  assign stall_event = valid_reg && !fetch_ready_i && !redir_taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_cnt_reg <= 32'd0;
      stall_cnt_reg    <= 32'd0;
    end else begin
      if (redir_taken) begin
        redirect_cnt_reg <= redirect_cnt_reg + 32'd1;
      end
      if (stall_event) begin
        stall_cnt_reg <= stall_cnt_reg + 32'd1;
      end
    end
  end

  assign redirect_cnt_o = redirect_cnt_reg;
  assign stall_cnt_o    = stall_cnt_reg;
`else
  assign redirect_cnt_o = 32'd0;
  assign stall_cnt_o    = 32'd0;
`endif

endmodule
